// File: rtl/hex_display_pkg.sv
// Shared types and segment constants for the 7-segment display loopback monitor.
// Segment patterns are active-low, bit0 = a .. bit6 = g.
package hex_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] nibble;
    logic       valid;
    logic       blank;
  } seg_dec_t;

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational glyph decoder: active-low 7-segment pattern to nibble,
// with separate flags for a recognised hex glyph and an all-off (blank) digit.
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [6:0] seg_i,
  output seg_dec_t   dec_o
);

  always_comb begin
    dec_o.nibble = 4'h0;
    dec_o.valid  = 1'b1;
    dec_o.blank  = 1'b0;
    case (seg_i)
      SEG_0:     dec_o.nibble = 4'h0;
      SEG_1:     dec_o.nibble = 4'h1;
      SEG_2:     dec_o.nibble = 4'h2;
      SEG_3:     dec_o.nibble = 4'h3;
      SEG_4:     dec_o.nibble = 4'h4;
      SEG_5:     dec_o.nibble = 4'h5;
      SEG_6:     dec_o.nibble = 4'h6;
      SEG_7:     dec_o.nibble = 4'h7;
      SEG_8:     dec_o.nibble = 4'h8;
      SEG_9:     dec_o.nibble = 4'h9;
      SEG_A:     dec_o.nibble = 4'hA;
      SEG_B:     dec_o.nibble = 4'hB;
      SEG_C:     dec_o.nibble = 4'hC;
      SEG_D:     dec_o.nibble = 4'hD;
      SEG_E:     dec_o.nibble = 4'hE;
      SEG_F:     dec_o.nibble = 4'hF;
      SEG_BLANK: begin
        dec_o.valid = 1'b0;
        dec_o.blank = 1'b1;
      end
      default:   dec_o.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/hex_display_monitor.sv
// Loopback reader for the multiplexed 7-segment bus: waits for each digit to
// settle, decodes it and tracks full frames. Optional error counter: HEX_DISPLAY_MONITOR_ERR_CNT_EN.
module hex_display_monitor
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    update,
  output logic                    frame_done,
  output logic                    invalid_pattern,
  output logic [7:0]              err_count
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   sel_q;
  logic [6:0]              snap_seg_q;
  logic [NUM_DIGITS-1:0]   snap_sel_q;
  logic [7:0]              cnt_q;
  state_e                  state_q;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic                    update_q;
  logic                    frame_q;
  logic                    inv_q;

  logic                    sel_ok;
  logic                    same;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   cap_bit;
  logic [NUM_DIGITS-1:0]   mask_d;
  seg_dec_t                dec;

  hex_seg_decode u_decode (
    .seg_i (snap_seg_q),
    .dec_o (dec)
  );

  always_comb begin
    sel_ok  = $onehot(~sel_q);
    same    = (seg_q == snap_seg_q) && (sel_q == snap_sel_q);
    capture = (state_q == SETTLE) && sel_ok && same && (cnt_q == STABLE_LIM);
    cap_bit = ~snap_sel_q;
    mask_d  = mask_q | cap_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q    <= '0;
      sel_q    <= '1;
      cnt_q    <= '0;
      state_q  <= IDLE;
      mask_q   <= '0;
      value_q  <= '0;
      valid_q  <= '0;
      blank_q  <= '0;
      update_q <= 1'b0;
      frame_q  <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      seg_q    <= seg_in;
      sel_q    <= dig_sel_n;
      update_q <= 1'b0;
      frame_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (sel_ok) begin
            snap_seg_q <= seg_q;
            snap_sel_q <= sel_q;
            cnt_q      <= 8'd1;
            state_q    <= SETTLE;
          end else begin
            cnt_q <= '0;
          end
        end
        SETTLE: begin
          if (!sel_ok) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (!same) begin
            snap_seg_q <= seg_q;
            snap_sel_q <= sel_q;
            cnt_q      <= 8'd1;
          end else if (cnt_q == STABLE_LIM) begin
            state_q <= CAPTURED;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        CAPTURED: begin
          if (!sel_ok) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (!same) begin
            snap_seg_q <= seg_q;
            snap_sel_q <= sel_q;
            cnt_q      <= 8'd1;
            state_q    <= SETTLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase

      // Capture writes only the digit selected by the snapshot; blank keeps the old nibble.
      if (capture) begin
        update_q <= 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (cap_bit[i]) begin
            if (dec.valid) begin
              value_q[4*i +: 4] <= dec.nibble;
              valid_q[i]        <= 1'b1;
              blank_q[i]        <= 1'b0;
            end else if (dec.blank) begin
              valid_q[i] <= 1'b0;
              blank_q[i] <= 1'b1;
            end else begin
              valid_q[i] <= 1'b0;
              blank_q[i] <= 1'b0;
            end
          end
        end
        if (!dec.valid && !dec.blank) begin
          inv_q <= 1'b1;
        end
        if (&mask_d) begin
          mask_q  <= '0;
          frame_q <= 1'b1;
        end else begin
          mask_q <= mask_d;
        end
      end
    end
  end

`ifdef HEX_DISPLAY_MONITOR_ERR_CNT_EN
  logic [7:0] err_q;
  logic       err_inc;

  always_comb begin
    err_inc = (capture && !dec.valid && !dec.blank) ||
              ((state_q == SETTLE) && !sel_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (err_inc && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

  assign value_out       = value_q;
  assign digit_valid     = valid_q;
  assign digit_blank     = blank_q;
  assign update          = update_q;
  assign frame_done      = frame_q;
  assign invalid_pattern = inv_q;

endmodule

// File: tb/tb_hex_display_monitor.sv
// Scoreboard bench for hex_display_monitor: directed glyph/select vectors push
// expected captures (with their arrival cycle); a monitor compares on update.
module tb_hex_display_monitor;

  localparam int NUM_DIGITS    = 4;
  localparam int STABLE_CYCLES = 16;
`ifdef HEX_DISPLAY_MONITOR_ERR_CNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif
  localparam logic [7:0] E1 = 8'(ERR_EN);
  localparam logic [7:0] E2 = 8'(2 * ERR_EN);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  dig_sel_n = 4'hF;
  logic [15:0] value_out;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_blank;
  logic        update;
  logic        frame_done;
  logic        invalid_pattern;
  logic [7:0]  err_count;

  int cyc = 0;
  int total = 0;
  int passed = 0;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    logic [3:0]  vld;
    logic [3:0]  blk;
    logic        fr;
    logic        inv;
    logic [7:0]  err;
  } exp_t;

  exp_t exp_q[$];

  hex_display_monitor #(
    .NUM_DIGITS    (NUM_DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .seg_in          (seg_in),
    .dig_sel_n       (dig_sel_n),
    .value_out       (value_out),
    .digit_valid     (digit_valid),
    .digit_blank     (digit_blank),
    .update          (update),
    .frame_done      (frame_done),
    .invalid_pattern (invalid_pattern),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    else passed++;
  endtask

  task automatic apply(input logic [3:0] sel, input logic [6:0] seg, input int hold,
                       input bit upd, input logic [15:0] v, input logic [3:0] vl,
                       input logic [3:0] bl, input bit fr, input bit inv, input logic [7:0] er);
    exp_t e;
    @(posedge clk); #1;
    dig_sel_n = sel;
    seg_in    = seg;
    if (upd) begin
      e.cyc = cyc + STABLE_CYCLES + 2;
      e.val = v; e.vld = vl; e.blk = bl; e.fr = fr; e.inv = inv; e.err = er;
      exp_q.push_back(e);
    end
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic hold_only(input logic [3:0] sel, input logic [6:0] seg, input int hold);
    apply(sel, seg, hold, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    dig_sel_n = 4'hF;
    seg_in    = 7'h7F;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_value"}, 32'(value_out), 32'h0);
    chk({tag, "_valid"}, 32'(digit_valid), 32'h0);
    chk({tag, "_blank"}, 32'(digit_blank), 32'h0);
    chk({tag, "_update"}, 32'(update), 32'h0);
    chk({tag, "_frame"}, 32'(frame_done), 32'h0);
    chk({tag, "_invalid"}, 32'(invalid_pattern), 32'h0);
    chk({tag, "_err"}, 32'(err_count), 32'h0);
  endtask

  // Monitor: every update must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (frame_done && !update) begin
        total++;
        $display("FAIL frame_without_update: frame_done=1 update=0 (cycle %0d)", cyc);
      end
      if (update) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_update: update=1 value=%0h, no capture required (cycle %0d)", value_out, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("upd_cycle", 32'(cyc), 32'(e.cyc));
          chk("upd_value", 32'(value_out), 32'(e.val));
          chk("upd_valid", 32'(digit_valid), 32'(e.vld));
          chk("upd_blank", 32'(digit_blank), 32'(e.blk));
          chk("upd_frame", 32'(frame_done), 32'(e.fr));
          chk("upd_invalid", 32'(invalid_pattern), 32'(e.inv));
          chk("upd_err", 32'(err_count), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d required=0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    rst = 1'b0;

    // Single stable glyph on digit 0
    apply(4'b1110, 7'h24, 24, 1'b1, 16'h0002, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'h00);

    // Flicker shorter than the settle window never captures
    do_reset();
    for (int i = 0; i < 13; i++) hold_only(4'b1110, (i % 2 == 0) ? 7'h24 : 7'h30, 8);
    apply(4'b1110, 7'h30, 24, 1'b1, 16'h0003, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'h00);

    // Full scan: 0, 1, F, blank; frame completes on digit 3
    do_reset();
    apply(4'b1110, 7'h40, 32, 1'b1, 16'h0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'h00);
    apply(4'b1101, 7'h79, 32, 1'b1, 16'h0010, 4'b0011, 4'b0000, 1'b0, 1'b0, 8'h00);
    apply(4'b1011, 7'h0E, 32, 1'b1, 16'h0F10, 4'b0111, 4'b0000, 1'b0, 1'b0, 8'h00);
    apply(4'b0111, 7'h7F, 32, 1'b1, 16'h0F10, 4'b0111, 4'b1000, 1'b1, 1'b0, 8'h00);

    // Undecodable glyph on digit 1, then a good one; flag stays sticky
    apply(4'b1101, 7'h55, 32, 1'b1, 16'h0F10, 4'b0101, 4'b1000, 1'b0, 1'b1, E1);
    apply(4'b1101, 7'h79, 32, 1'b1, 16'h0F10, 4'b0111, 4'b1000, 1'b0, 1'b1, E1);

    // Two-hot select: leaving CAPTURED does not count, interrupting SETTLE does
    hold_only(4'b1100, 7'h7F, 40);
    #1 chk("err_after_captured_exit", 32'(err_count), 32'(E1));
    hold_only(4'b1110, 7'h12, 6);
    hold_only(4'b1100, 7'h12, 40);
    #1 chk("err_after_settle_exit", 32'(err_count), 32'(E2));
    chk("invalid_still_set", 32'(invalid_pattern), 32'h1);

    // Reset in the middle of SETTLE, then a full settle window again
    do_reset();
    hold_only(4'b1110, 7'h21, 10);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("mid_settle_reset");
    rst = 1'b0;
    begin
      exp_t e;
      e.cyc = cyc + STABLE_CYCLES + 2;
      e.val = 16'h000D; e.vld = 4'b0001; e.blk = 4'b0000; e.fr = 1'b0; e.inv = 1'b0; e.err = 8'h00;
      exp_q.push_back(e);
    end
    repeat (30) @(posedge clk);

    repeat (5) @(posedge clk);
    #1 chk("pending_expectations", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
